// File: rtl/user_id_bank_if.sv
// Read request / response channel of the ID bank.
// The master drives requests; the slave (the bank) returns a registered response.
interface user_id_bank_if #(
   parameter int unsigned WORD_W = 32
);
   logic              rd_valid;
   logic [4:0]        rd_addr;
   logic              rd_ready;
   logic              rsp_valid;
   logic [WORD_W-1:0] rsp_data;
   logic              rsp_err;
   logic              rsp_ready;

   modport master (
      output rd_valid, rd_addr, rsp_ready,
      input  rd_ready, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      input  rd_valid, rd_addr, rsp_ready,
      output rd_ready, rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/user_id_bank.sv
// Mask-programmed ID bank with lockable per-word overrides, a checksum word,
// a single-entry read response register and an LSB-first serial dump engine.
module user_id_bank #(
   parameter int unsigned                    NUM_WORDS = 4,
   parameter int unsigned                    WORD_W    = 32,
   parameter logic [NUM_WORDS*WORD_W-1:0]    ID_VALUE  = '0
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              ovr_we,
   input  logic [3:0]        ovr_addr,
   input  logic [WORD_W-1:0] ovr_data,
   input  logic              lock_set,
   user_id_bank_if.slave     rd_if,
   input  logic              dump_start,
   output logic              sdo,
   output logic              sdo_valid,
   output logic              dump_busy,
   output logic              dump_done,
   output logic              locked,
   output logic [WORD_W-1:0] mask_rev
);

   localparam int unsigned TOT_BITS = NUM_WORDS * WORD_W;
   localparam int unsigned CNT_W    = $clog2(TOT_BITS) + 1;

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;

   logic [WORD_W-1:0]   ovr_reg_q [NUM_WORDS];
   logic [WORD_W-1:0]   ovr_reg_d [NUM_WORDS];
   logic [NUM_WORDS-1:0] ovr_set_q, ovr_set_d;
   logic                locked_q, locked_d;

   logic [WORD_W-1:0]   eff [NUM_WORDS];
   logic [WORD_W-1:0]   csum;

   logic                rd_ready;
   logic                rd_accept;
   logic [WORD_W-1:0]   rd_word;
   logic                rd_err;
   logic                rsp_valid_q, rsp_valid_d;
   logic [WORD_W-1:0]   rsp_data_q, rsp_data_d;
   logic                rsp_err_q, rsp_err_d;

   logic [0:0]          state_q, state_d;
   logic [TOT_BITS-1:0] shift_q, shift_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                done_q, done_d;

   always_comb begin
      csum = '0;
      for (int unsigned i = 0; i < NUM_WORDS; i++) begin
         eff[i] = ovr_set_q[i] ? ovr_reg_q[i] : ID_VALUE[i*WORD_W +: WORD_W];
         csum   = csum ^ eff[i];
      end
   end

   // Writes act on locked_q, so a write paired with lock_set still lands.
   always_comb begin
      ovr_reg_d = ovr_reg_q;
      ovr_set_d = ovr_set_q;
      locked_d  = locked_q | lock_set;
      if (ovr_we && !locked_q) begin
         for (int unsigned i = 0; i < NUM_WORDS; i++) begin
            if (ovr_addr == 4'(i)) begin
               ovr_reg_d[i] = ovr_data;
               ovr_set_d[i] = 1'b1;
            end
         end
      end
   end

   assign rd_ready  = !rsp_valid_q || rd_if.rsp_ready;
   assign rd_accept = rd_if.rd_valid && rd_ready;

   always_comb begin
      rd_word = '0;
      rd_err  = 1'b1;
      for (int unsigned i = 0; i < NUM_WORDS; i++) begin
         if (rd_if.rd_addr == 5'(i)) begin
            rd_word = eff[i];
            rd_err  = 1'b0;
         end
      end
      if (rd_if.rd_addr == 5'(NUM_WORDS)) begin
         rd_word = csum;
         rd_err  = 1'b0;
      end
   end

   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      if (rd_accept) begin
         rsp_valid_d = 1'b1;
         rsp_data_d  = rd_word;
         rsp_err_d   = rd_err;
      end else if (rd_if.rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (dump_start) begin
               state_d = SHIFT;
               cnt_d   = '0;
               for (int unsigned i = 0; i < NUM_WORDS; i++) begin
                  shift_d[i*WORD_W +: WORD_W] = eff[i];
               end
            end
         end
         SHIFT: begin
            shift_d = shift_q >> 1;
            if (cnt_q == CNT_W'(TOT_BITS - 1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         for (int unsigned i = 0; i < NUM_WORDS; i++) begin
            ovr_reg_q[i] <= '0;
         end
         ovr_set_q   <= '0;
         locked_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         state_q     <= IDLE;
         shift_q     <= '0;
         cnt_q       <= '0;
         done_q      <= 1'b0;
      end else begin
         ovr_reg_q   <= ovr_reg_d;
         ovr_set_q   <= ovr_set_d;
         locked_q    <= locked_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         state_q     <= state_d;
         shift_q     <= shift_d;
         cnt_q       <= cnt_d;
         done_q      <= done_d;
      end
   end

   assign rd_if.rd_ready  = rd_ready;
   assign rd_if.rsp_valid = rsp_valid_q;
   assign rd_if.rsp_data  = rsp_data_q;
   assign rd_if.rsp_err   = rsp_err_q;

   assign sdo_valid = (state_q == SHIFT);
   assign dump_busy = (state_q == SHIFT);
   assign sdo       = (state_q == SHIFT) & shift_q[0];
   assign dump_done = done_q;
   assign locked    = locked_q;
   assign mask_rev  = eff[0];

endmodule

// File: tb/tb_user_id_bank.sv
// Directed self-checking bench for user_id_bank: reads, back-pressure,
// override/lock, serial dump and reset abort.
module tb_user_id_bank;

   localparam logic [127:0] ID = {32'hFFFF_FFFF, 32'h0000_0000, 32'hCAFE_0001, 32'h1234_5678};

   logic        clk = 1'b0;
   logic        rst;
   logic        ovr_we;
   logic [3:0]  ovr_addr;
   logic [31:0] ovr_data;
   logic        lock_set;
   logic        dump_start;
   logic        sdo, sdo_valid, dump_busy, dump_done, locked;
   logic [31:0] mask_rev;

   int n_checks = 0;
   int n_fail   = 0;

   user_id_bank_if #(.WORD_W(32)) rd_bus ();

   user_id_bank #(
      .NUM_WORDS (4),
      .WORD_W    (32),
      .ID_VALUE  (ID)
   ) u_dut (
      .wb_clk_i   (clk),
      .wb_rst_i   (rst),
      .ovr_we     (ovr_we),
      .ovr_addr   (ovr_addr),
      .ovr_data   (ovr_data),
      .lock_set   (lock_set),
      .rd_if      (rd_bus.slave),
      .dump_start (dump_start),
      .sdo        (sdo),
      .sdo_valid  (sdo_valid),
      .dump_busy  (dump_busy),
      .dump_done  (dump_done),
      .locked     (locked),
      .mask_rev   (mask_rev)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; ovr_we = 1'b0; ovr_addr = '0; ovr_data = '0; lock_set = 1'b0;
      dump_start = 1'b0; rd_bus.rd_valid = 1'b0; rd_bus.rd_addr = '0; rd_bus.rsp_ready = 1'b1;
      tick; tick;
      n_checks++; if (rd_bus.rd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rd_ready got %b exp 1", rd_bus.rd_ready); end
      n_checks++; if (rd_bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b exp 0", rd_bus.rsp_valid); end
      n_checks++; if (rd_bus.rsp_data !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_data got %h exp 0", rd_bus.rsp_data); end
      n_checks++; if ({sdo, sdo_valid, dump_busy, dump_done, locked} !== 5'b0) begin
         n_fail++; $display("FAIL reset_flags got %b exp 00000", {sdo, sdo_valid, dump_busy, dump_done, locked}); end
      n_checks++; if (mask_rev !== 32'h1234_5678) begin n_fail++; $display("FAIL reset_mask_rev got %h exp 12345678", mask_rev); end
      rst = 1'b0;
      tick;
   endtask

   task automatic test_reads;
      logic [31:0] exp_d [6];
      exp_d = '{32'h1234_5678, 32'hCAFE_0001, 32'h0, 32'hFFFF_FFFF, 32'h2735_A986, 32'h0};
      rd_bus.rsp_ready = 1'b1;
      for (int a = 0; a < 6; a++) begin
         rd_bus.rd_valid = 1'b1;
         rd_bus.rd_addr  = 5'(a);
         tick;
         n_checks++; if (rd_bus.rsp_valid !== 1'b1 || rd_bus.rsp_data !== exp_d[a] || rd_bus.rsp_err !== (a == 5)) begin
            n_fail++; $display("FAIL read_addr%0d got v=%b d=%h e=%b exp v=1 d=%h e=%b",
                               a, rd_bus.rsp_valid, rd_bus.rsp_data, rd_bus.rsp_err, exp_d[a], (a == 5)); end
         n_checks++; if (rd_bus.rd_ready !== 1'b1) begin n_fail++; $display("FAIL read_ready%0d got %b exp 1", a, rd_bus.rd_ready); end
      end
      rd_bus.rd_valid = 1'b0;
      tick;
      n_checks++; if (rd_bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL read_drain got %b exp 0", rd_bus.rsp_valid); end
   endtask

   task automatic test_back_to_back;
      rd_bus.rsp_ready = 1'b1; rd_bus.rd_valid = 1'b1; rd_bus.rd_addr = 5'd0;
      tick;
      rd_bus.rsp_ready = 1'b0; rd_bus.rd_addr = 5'd1;
      #1;
      n_checks++; if (rd_bus.rd_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready got %b exp 0", rd_bus.rd_ready); end
      for (int c = 0; c < 3; c++) begin
         tick;
         n_checks++; if (rd_bus.rsp_valid !== 1'b1 || rd_bus.rsp_data !== 32'h1234_5678 || rd_bus.rd_ready !== 1'b0) begin
            n_fail++; $display("FAIL stall_hold%0d got v=%b d=%h rdy=%b exp v=1 d=12345678 rdy=0",
                               c, rd_bus.rsp_valid, rd_bus.rsp_data, rd_bus.rd_ready); end
      end
      rd_bus.rsp_ready = 1'b1;
      tick;
      rd_bus.rd_valid = 1'b0;
      n_checks++; if (rd_bus.rsp_valid !== 1'b1 || rd_bus.rsp_data !== 32'hCAFE_0001) begin
         n_fail++; $display("FAIL stall_release got v=%b d=%h exp v=1 d=cafe0001", rd_bus.rsp_valid, rd_bus.rsp_data); end
      tick;
      n_checks++; if (rd_bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL stall_nodup got %b exp 0", rd_bus.rsp_valid); end
   endtask

   task automatic test_dump;
      logic [127:0] stream;
      logic [7:0]   first8;
      int nvalid, ndone, bit_err, idx;
      stream = ID; first8 = 8'b0111_1000;
      nvalid = 0; ndone = 0; bit_err = 0; idx = 0;
      dump_start = 1'b1;
      for (int c = 0; c < 270; c++) begin
         tick;
         if (c == 0)  dump_start = 1'b0;
         if (c == 20) dump_start = 1'b1;
         if (c == 21) dump_start = 1'b0;
         if (c < 8) begin
            n_checks++; if (sdo !== first8[c] || sdo_valid !== 1'b1) begin
               n_fail++; $display("FAIL dump_bit%0d got sdo=%b v=%b exp sdo=%b v=1", c, sdo, sdo_valid, first8[c]); end
         end
         if (c == 128) begin
            n_checks++; if (dump_done !== 1'b1 || sdo_valid !== 1'b0) begin
               n_fail++; $display("FAIL dump_end got done=%b v=%b exp done=1 v=0", dump_done, sdo_valid); end
            dump_start = 1'b1;
         end
         if (c == 129) begin
            dump_start = 1'b0;
            n_checks++; if (sdo_valid !== 1'b1 || dump_done !== 1'b0) begin
               n_fail++; $display("FAIL dump_restart got v=%b done=%b exp v=1 done=0", sdo_valid, dump_done); end
         end
         if (sdo_valid) begin
            if (sdo !== stream[idx % 128]) bit_err++;
            idx++; nvalid++;
         end else if (sdo !== 1'b0) begin
            bit_err++;
         end
         if (dump_busy !== sdo_valid) bit_err++;
         if (dump_done) ndone++;
      end
      n_checks++; if (nvalid != 256) begin n_fail++; $display("FAIL dump_valid_cycles got %0d exp 256", nvalid); end
      n_checks++; if (ndone != 2) begin n_fail++; $display("FAIL dump_done_pulses got %0d exp 2", ndone); end
      n_checks++; if (bit_err != 0) begin n_fail++; $display("FAIL dump_stream_errors got %0d exp 0", bit_err); end
   endtask

   task automatic test_override_lock;
      rd_bus.rsp_ready = 1'b1;
      ovr_we = 1'b1; ovr_addr = 4'd5; ovr_data = 32'hDEAD_BEEF;
      tick;
      ovr_addr = 4'd2; ovr_data = 32'h0000_FFFF;
      rd_bus.rd_valid = 1'b1; rd_bus.rd_addr = 5'd2;
      tick;
      n_checks++; if (rd_bus.rsp_data !== 32'h0 || rd_bus.rsp_err !== 1'b0) begin
         n_fail++; $display("FAIL ovr_prewrite got d=%h e=%b exp d=0 e=0", rd_bus.rsp_data, rd_bus.rsp_err); end
      rd_bus.rd_valid = 1'b0;
      ovr_addr = 4'd0; ovr_data = 32'hA5A5_A5A5; lock_set = 1'b1;
      tick;
      lock_set = 1'b0;
      n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_set got %b exp 1", locked); end
      n_checks++; if (mask_rev !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL lock_same_cycle got %h exp a5a5a5a5", mask_rev); end
      ovr_addr = 4'd2; ovr_data = 32'h0;
      tick;
      ovr_addr = 4'd0;
      tick;
      ovr_we = 1'b0;
      rd_bus.rd_valid = 1'b1; rd_bus.rd_addr = 5'd2;
      tick;
      n_checks++; if (rd_bus.rsp_data !== 32'h0000_FFFF) begin n_fail++; $display("FAIL locked_word2 got %h exp 0000ffff", rd_bus.rsp_data); end
      rd_bus.rd_addr = 5'd0;
      tick;
      n_checks++; if (rd_bus.rsp_data !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL locked_word0 got %h exp a5a5a5a5", rd_bus.rsp_data); end
      rd_bus.rd_addr = 5'd4;
      tick;
      n_checks++; if (rd_bus.rsp_data !== 32'h90A4_A5A4) begin n_fail++; $display("FAIL ovr_checksum got %h exp 90a4a5a4", rd_bus.rsp_data); end
      rd_bus.rd_valid = 1'b0;
      tick;
   endtask

   task automatic test_reset_abort;
      int ndone;
      ndone = 0;
      dump_start = 1'b1;
      tick;
      dump_start = 1'b0;
      rd_bus.rd_valid = 1'b1; rd_bus.rd_addr = 5'd0; rd_bus.rsp_ready = 1'b0;
      tick;
      rd_bus.rd_valid = 1'b0;
      repeat (49) tick;
      n_checks++; if (sdo_valid !== 1'b1 || rd_bus.rsp_valid !== 1'b1) begin
         n_fail++; $display("FAIL abort_pre got v=%b rsp=%b exp 1 1", sdo_valid, rd_bus.rsp_valid); end
      #2 rst = 1'b1;
      #1;
      n_checks++; if ({sdo, sdo_valid, dump_busy, dump_done} !== 4'b0) begin
         n_fail++; $display("FAIL abort_dump got %b exp 0000", {sdo, sdo_valid, dump_busy, dump_done}); end
      n_checks++; if (locked !== 1'b0 || mask_rev !== 32'h1234_5678) begin
         n_fail++; $display("FAIL abort_ovr got lock=%b mask=%h exp lock=0 mask=12345678", locked, mask_rev); end
      n_checks++; if (rd_bus.rsp_valid !== 1'b0 || rd_bus.rd_ready !== 1'b1) begin
         n_fail++; $display("FAIL abort_rsp got v=%b rdy=%b exp v=0 rdy=1", rd_bus.rsp_valid, rd_bus.rd_ready); end
      repeat (3) begin tick; if (dump_done) ndone++; end
      rst = 1'b0; rd_bus.rsp_ready = 1'b1;
      repeat (5) begin tick; if (dump_done) ndone++; end
      n_checks++; if (ndone != 0) begin n_fail++; $display("FAIL abort_no_done got %0d exp 0", ndone); end
      rd_bus.rd_valid = 1'b1; rd_bus.rd_addr = 5'd2;
      tick;
      n_checks++; if (rd_bus.rsp_data !== 32'h0) begin n_fail++; $display("FAIL abort_word2 got %h exp 0", rd_bus.rsp_data); end
      rd_bus.rd_valid = 1'b0;
      tick;
   endtask

   initial begin
      test_reset;
      test_reads;
      test_back_to_back;
      test_dump;
      test_override_lock;
      test_reset_abort;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
